// File: rtl/stream_led_sched.sv
// Four-mode LED pattern scheduler for the 8-LED stream display.
// A debounced button press or an auto-advance after AUTO_STEPS ticks moves to the next mode.
module stream_led_sched #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int AUTO_STEPS      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          btn,
  input  logic                          auto_en,
  output logic [7:0]                    led_io,
  output logic [1:0]                    mode,
  output logic [$clog2(AUTO_STEPS)-1:0] step_cnt
);

  localparam int SW = $clog2(AUTO_STEPS);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  logic          sync1_q, sync2_q;
  logic          db_q, db_d, db_dly_q, press_q;
  logic [DW-1:0] dbc_q, dbc_d;
  mode_e         mode_q, mode_d;
  logic [7:0]    led_q, led_d;
  logic [SW-1:0] step_q, step_d;
  logic          dir_q, dir_d;      // 0 = moving left, 1 = moving right
  logic          phase_q, phase_d;  // 0 = fill, 1 = clear
  logic          last_step, advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      press_q  <= 1'b0;
      dbc_q    <= '0;
      mode_q   <= MODE_ROL;
      led_q    <= 8'h01;
      step_q   <= '0;
      dir_q    <= 1'b0;
      phase_q  <= 1'b0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      press_q  <= db_q & ~db_dly_q;
      dbc_q    <= dbc_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      phase_q  <= phase_d;
    end
  end

  // The debounced level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_d  = db_q;
    dbc_d = '0;
    if (sync2_q != db_q) begin
      if (dbc_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_d  = sync2_q;
        dbc_d = '0;
      end else begin
        dbc_d = dbc_q + DW'(1);
      end
    end
  end

  assign last_step = (step_q == SW'(AUTO_STEPS - 1));
  assign advance   = press_q | (tick & auto_en & last_step);

  always_comb begin
    mode_d  = mode_q;
    led_d   = led_q;
    step_d  = step_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    if (advance) begin
      // A mode change discards any pattern step due in the same cycle.
      step_d  = '0;
      dir_d   = 1'b0;
      phase_d = 1'b0;
      case (mode_q)
        MODE_ROL:    begin mode_d = MODE_ROR;    led_d = 8'h80; end
        MODE_ROR:    begin mode_d = MODE_BOUNCE; led_d = 8'h01; end
        MODE_BOUNCE: begin mode_d = MODE_FILL;   led_d = 8'h00; end
        default:     begin mode_d = MODE_ROL;    led_d = 8'h01; end
      endcase
    end else if (tick) begin
      step_d = last_step ? '0 : step_q + SW'(1);
      case (mode_q)
        MODE_ROL: led_d = {led_q[6:0], led_q[7]};
        MODE_ROR: led_d = {led_q[0], led_q[7:1]};
        MODE_BOUNCE: begin
          if (!dir_q) begin
            led_d = {led_q[6:0], 1'b0};
            if (led_d == 8'h80) dir_d = 1'b1;
          end else begin
            led_d = {1'b0, led_q[7:1]};
            if (led_d == 8'h01) dir_d = 1'b0;
          end
        end
        default: begin
          if (!phase_q) begin
            led_d = {led_q[6:0], 1'b1};
            if (led_d == 8'hFF) phase_d = 1'b1;
          end else begin
            led_d = {led_q[6:0], 1'b0};
            if (led_d == 8'h00) phase_d = 1'b0;
          end
        end
      endcase
    end
  end

  assign led_io   = led_q;
  assign mode     = mode_q;
  assign step_cnt = step_q;

endmodule

// File: tb/tb_stream_led_sched.sv
// Bench for stream_led_sched: directed scenarios plus random traffic, every cycle
// checked against a pattern-table model with a windowed button debouncer.
module tb_stream_led_sched;

  localparam int DC   = 20;
  localparam int AS   = 16;
  localparam int SW   = $clog2(AS);
  localparam int MAXE = 20000;

  logic          clk = 1'b0;
  logic          reset, tick, btn, auto_en;
  logic [7:0]    led_io;
  logic [1:0]    mode;
  logic [SW-1:0] step_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [13:0] exp_q[$];

  // Model state: pattern index since mode entry, plus debounced-button history.
  int m_mode = 0, m_idx = 0, m_step = 0, m_last_flip = 0;
  bit m_db = 0, m_press = 0, m_rose = 0;
  bit samp [0:MAXE-1];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  stream_led_sched #(.DEBOUNCE_CYCLES(DC), .AUTO_STEPS(AS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn(btn), .auto_en(auto_en),
    .led_io(led_io), .mode(mode), .step_cnt(step_cnt)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] pat(int md, int idx);
    int p, v;
    v = 0;
    case (md)
      0: v = 1 << (idx % 8);
      1: v = 128 >> (idx % 8);
      2: begin p = idx % 14; v = (p <= 7) ? (1 << p) : (1 << (14 - p)); end
      default: begin p = idx % 16; v = (p <= 8) ? ((1 << p) - 1) : ((255 << (p - 8)) & 255); end
    endcase
    return v[7:0];
  endfunction

  task automatic model_edge(bit r, bit tk, bit b, bit au);
    int n;
    bit adv, new_press, rose_now, all_diff;
    n = cyc;
    samp[n] = b;
    rose_now = 0;
    if (r) begin
      m_mode = 0; m_idx = 0; m_step = 0;
      m_db = 0; m_press = 0; m_rose = 0; m_last_flip = n;
      samp[n] = 0; samp[n-1] = 0;
    end else begin
      adv = m_press || (tk && au && m_step == AS - 1);
      if (adv) begin
        m_mode = (m_mode + 1) % 4; m_idx = 0; m_step = 0;
      end else if (tk) begin
        m_idx++; m_step = (m_step + 1) % AS;
      end
      new_press = m_rose;
      // Synchronised sample seen at edge k is the raw sample from edge k-2.
      if (n - m_last_flip >= DC) begin
        all_diff = 1;
        for (int k = n - DC - 1; k <= n - 2; k++) if (samp[k] == m_db) all_diff = 0;
        if (all_diff) begin
          m_db = !m_db; m_last_flip = n; rose_now = m_db;
        end
      end
      m_press = new_press;
      m_rose  = rose_now;
    end
    exp_q.push_back({m_mode[1:0], m_step[3:0], pat(m_mode, m_idx)});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string tag, logic [7:0] got, logic [7:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc_step(bit r, bit tk, bit b, bit au);
    logic [13:0] e;
    reset = r; tick = tk; btn = b; auto_en = au;
    @(posedge clk);
    cyc++;
    model_edge(r, tk, b, au);
    #1;
    e = exp_q.pop_front();
    check("led",  led_io,             e[7:0]);
    check("mode", {6'b0, mode},       {6'b0, e[13:12]});
    check("step", {4'b0, step_cnt},   {4'b0, e[11:8]});
    @(negedge clk);
  endtask

  task automatic idle(int n, bit b, bit au);
    for (int i = 0; i < n; i++) cyc_step(0, 0, b, au);
  endtask

  task automatic do_reset();
    cyc_step(1, 0, 0, 0);
    cyc_step(1, 0, 0, 0);
  endtask

  task automatic press_release();
    idle(24, 1, 0);
    idle(30, 0, 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [7:0] t1 [9];
  bit seg_b, seg_au;
  int seg_len;

  initial begin
    t1 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    reset = 1; tick = 0; btn = 0; auto_en = 0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_led", led_io, 8'h01);
    check("rst_mode", {6'b0, mode}, 8'h00);
    check("rst_step", {4'b0, step_cnt}, 8'h00);

    // Rotate-left with 9 ticks
    for (int i = 0; i < 9; i++) begin
      cyc_step(0, 1, 0, 0);
      check("t1_led", led_io, t1[i]);
    end
    check("t1_step", {4'b0, step_cnt}, 8'd9);
    check("t1_mode", {6'b0, mode}, 8'h00);

    // Press latency: btn first sampled high at edge t
    for (int k = 0; k <= 22; k++) cyc_step(0, 0, 1, 0);
    check("t2_early_mode", {6'b0, mode}, 8'h00);
    cyc_step(0, 0, 1, 0);
    check("t2_mode", {6'b0, mode}, 8'h01);
    check("t2_led", led_io, 8'h80);
    cyc_step(0, 1, 1, 0); check("t2_tick1", led_io, 8'h40);
    cyc_step(0, 1, 1, 0); check("t2_tick2", led_io, 8'h20);
    cyc_step(0, 1, 1, 0); check("t2_tick3", led_io, 8'h10);
    idle(30, 0, 0);

    // Short pulses are rejected
    for (int r = 0; r < 5; r++) begin
      idle(19, 1, 0);
      idle(30, 0, 0);
    end
    check("t3_mode", {6'b0, mode}, 8'h01);
    check("t3_led", led_io, 8'h10);

    // Auto-advance over 64 ticks
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      cyc_step(0, 1, 0, 1);
      if (i % 16 == 0) begin
        check("t4_mode", {6'b0, mode}, 8'((i / 16) % 4));
        check("t4_step", {4'b0, step_cnt}, 8'h00);
      end
      if (i == 63) check("t4_fill_end", led_io, 8'h80);
    end

    // Press aligned with the auto-advance tick
    do_reset();
    cyc_step(0, 0, 1, 1);
    for (int k = 1; k <= 15; k++) cyc_step(0, 1, 1, 1);
    for (int k = 16; k <= 22; k++) cyc_step(0, 0, 1, 1);
    cyc_step(0, 1, 1, 1);
    check("t5_mode", {6'b0, mode}, 8'h01);
    check("t5_led", led_io, 8'h80);
    check("t5_step", {4'b0, step_cnt}, 8'h00);
    idle(30, 0, 0);

    // Reset wins over a concurrent tick and press
    do_reset();
    for (int p = 0; p < 3; p++) press_release();
    for (int k = 0; k < 6; k++) cyc_step(0, 1, 0, 0);
    check("t6_pre_mode", {6'b0, mode}, 8'h03);
    check("t6_pre_led", led_io, 8'h3F);
    for (int k = 0; k <= 22; k++) cyc_step(0, 0, 1, 0);
    cyc_step(1, 1, 0, 0);
    check("t6_mode", {6'b0, mode}, 8'h00);
    check("t6_led", led_io, 8'h01);
    check("t6_step", {4'b0, step_cnt}, 8'h00);
    cyc_step(0, 1, 0, 0); check("t6_tick1", led_io, 8'h02);
    cyc_step(0, 1, 0, 0); check("t6_tick2", led_io, 8'h04);

    // Random traffic: button segments of random length, random ticks, rare resets
    for (int s = 0; s < 60; s++) begin
      seg_b   = 1'($urandom_range(0, 1));
      seg_au  = 1'($urandom_range(0, 1));
      seg_len = $urandom_range(1, 60);
      for (int i = 0; i < seg_len; i++)
        cyc_step(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) == 0), seg_b, seg_au);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
